// File: rtl/dvfs_pkg.sv
// Shared types, code-width constants and request clamping for the DVFS transition sequencer.
package dvfs_pkg;

    localparam int CODE_W = 3;
    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(6);

    typedef enum logic [2:0] {
        IDLE,
        V_SET,
        V_WAIT,
        F_SET,
        F_WAIT
    } dvfs_state_e;

    // Code 7 duplicates 6 in the characterization table, so MAX_CODE caps every target.
    function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] req,
                                                     input logic [CODE_W-1:0] ceil);
        logic [CODE_W-1:0] m;
        m = (req < ceil) ? req : ceil;
        return (m > MAX_CODE) ? MAX_CODE : m;
    endfunction

endpackage

// File: rtl/dvfs_settle_timer.sv
// Shared settle down-counter; expired is high for the single cycle the count sits at 1.
module dvfs_settle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] value,
    output logic       expired
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= (value == 8'd0) ? 8'd1 : value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    // The N-th counted cycle is the one spent at 1, so the owning WAIT state exits on that edge.
    assign expired = (count == 8'd1);

endmodule

// File: rtl/dvfs_transition_sequencer.sv
// Orders voltage/frequency override steps for one tile: voltage leads on the way up,
// frequency leads on the way down, with a settle wait after each step and a thermal fallback to code 0.
module dvfs_transition_sequencer
    import dvfs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [CODE_W-1:0] req_code,
    output logic              req_ready,
    input  logic [CODE_W-1:0] max_code_cfg,
    input  logic [7:0]        settle_cycles_cfg,
    input  logic              thermal_trip,
    output logic              frequency_override_en,
    output logic [CODE_W-1:0] frequency_override,
    output logic              voltage_override_en,
    output logic [CODE_W-1:0] voltage_override,
    output logic [CODE_W-1:0] cur_code,
    output logic              busy,
    output logic              done_pulse,
    output logic              clamp_pulse
);

    dvfs_state_e       state;
    logic [CODE_W-1:0] tgt;
    logic              move_up;
    logic              trip_pending;
    logic              acc_same;
    logic              acc_clamp;
    logic [CODE_W-1:0] req_tgt;
    logic              timer_load;
    logic              expired;
    logic              final_done;

    assign req_tgt    = clamp_code(req_code, max_code_cfg);
    assign req_ready  = (state == IDLE) && !trip_pending && !thermal_trip;
    assign timer_load = (state == V_SET) || (state == F_SET);
    assign final_done = expired && (((state == V_WAIT) && !move_up) ||
                                    ((state == F_WAIT) &&  move_up));

    dvfs_settle_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .value   (settle_cycles_cfg),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            tgt                   <= '0;
            move_up               <= 1'b0;
            cur_code              <= '0;
            frequency_override    <= '0;
            voltage_override      <= '0;
            frequency_override_en <= 1'b0;
            voltage_override_en   <= 1'b0;
            busy                  <= 1'b0;
            done_pulse            <= 1'b0;
            clamp_pulse           <= 1'b0;
            trip_pending          <= 1'b0;
            acc_same              <= 1'b0;
            acc_clamp             <= 1'b0;
        end else begin
            // Accept-time flags surface one cycle later as the registered strobes.
            done_pulse  <= acc_same;
            clamp_pulse <= acc_clamp;
            acc_same    <= 1'b0;
            acc_clamp   <= 1'b0;

            if (thermal_trip && (state != IDLE)) begin
                trip_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (thermal_trip) begin
                        if (cur_code != '0) begin
                            tgt     <= '0;
                            move_up <= 1'b0;
                            state   <= F_SET;
                        end
                    end else if (req_valid && req_ready) begin
                        acc_clamp <= (req_tgt != req_code);
                        if (req_tgt == cur_code) begin
                            acc_same <= 1'b1;
                        end else begin
                            tgt     <= req_tgt;
                            move_up <= (req_tgt > cur_code);
                            state   <= (req_tgt > cur_code) ? V_SET : F_SET;
                        end
                    end
                end
                V_SET: begin
                    voltage_override      <= tgt;
                    voltage_override_en   <= 1'b1;
                    frequency_override_en <= 1'b1;
                    busy                  <= 1'b1;
                    state                 <= V_WAIT;
                end
                F_SET: begin
                    frequency_override    <= tgt;
                    voltage_override_en   <= 1'b1;
                    frequency_override_en <= 1'b1;
                    busy                  <= 1'b1;
                    state                 <= F_WAIT;
                end
                V_WAIT: if (expired && move_up)  state <= F_SET;
                F_WAIT: if (expired && !move_up) state <= V_SET;
                default: state <= IDLE;
            endcase

            // A trip seen during the move is honoured only once the move has landed safely.
            if (final_done) begin
                cur_code     <= tgt;
                done_pulse   <= 1'b1;
                trip_pending <= 1'b0;
                if ((trip_pending || thermal_trip) && (tgt != '0)) begin
                    tgt     <= '0;
                    move_up <= 1'b0;
                    state   <= F_SET;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Directed bench for the DVFS transition sequencer with hand-computed edge timings.
module tb_dvfs_transition_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_code;
    logic       req_ready;
    logic [2:0] max_code_cfg;
    logic [7:0] settle_cycles_cfg;
    logic       thermal_trip;
    logic       frequency_override_en;
    logic [2:0] frequency_override;
    logic       voltage_override_en;
    logic [2:0] voltage_override;
    logic [2:0] cur_code;
    logic       busy;
    logic       done_pulse;
    logic       clamp_pulse;

    int vectors = 0;
    int miscompares = 0;

    dvfs_transition_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .req_valid             (req_valid),
        .req_code              (req_code),
        .req_ready             (req_ready),
        .max_code_cfg          (max_code_cfg),
        .settle_cycles_cfg     (settle_cycles_cfg),
        .thermal_trip          (thermal_trip),
        .frequency_override_en (frequency_override_en),
        .frequency_override    (frequency_override),
        .voltage_override_en   (voltage_override_en),
        .voltage_override      (voltage_override),
        .cur_code              (cur_code),
        .busy                  (busy),
        .done_pulse            (done_pulse),
        .clamp_pulse           (clamp_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench just after accept edge T.
    task automatic accept(input logic [2:0] code);
        req_valid = 1'b1;
        req_code  = code;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = 0;
        while (!done_pulse && n < bound) begin
            tick();
            n++;
        end
        vectors++;
        if (done_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: done_pulse not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({cur_code, frequency_override, voltage_override, frequency_override_en,
             voltage_override_en, busy, done_pulse, clamp_pulse, req_ready} !== 15'b000_000_000_0_0_0_0_0_1) begin
            miscompares++;
            $display("FAIL reset_values: cur=%0d f=%0d v=%0d fen=%b ven=%b busy=%b done=%b clamp=%b rdy=%b, required all 0 and rdy=1",
                     cur_code, frequency_override, voltage_override, frequency_override_en,
                     voltage_override_en, busy, done_pulse, clamp_pulse, req_ready);
        end
    endtask

    task automatic test_upward();
        settle_cycles_cfg = 8'd20;
        max_code_cfg      = 3'd7;
        accept(3'd3);
        tick();
        vectors++;
        if ({voltage_override, frequency_override, voltage_override_en, frequency_override_en, busy} !== {3'd3, 3'd0, 3'b111}) begin
            miscompares++;
            $display("FAIL up_T+1: v=%0d f=%0d ven=%b fen=%b busy=%b, required v=3 f=0 en=1 busy=1",
                     voltage_override, frequency_override, voltage_override_en, frequency_override_en, busy);
        end
        ticks(20);
        vectors++;
        if (frequency_override !== 3'd0) begin
            miscompares++;
            $display("FAIL up_T+21: f=%0d, required 0", frequency_override);
        end
        tick();
        vectors++;
        if (frequency_override !== 3'd3) begin
            miscompares++;
            $display("FAIL up_T+22: f=%0d, required 3", frequency_override);
        end
        ticks(19);
        vectors++;
        if ({done_pulse, cur_code, busy} !== {1'b0, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL up_T+41: done=%b cur=%0d busy=%b, required 0 0 1", done_pulse, cur_code, busy);
        end
        tick();
        vectors++;
        if ({done_pulse, cur_code, busy, req_ready} !== {1'b1, 3'd3, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL up_T+42: done=%b cur=%0d busy=%b rdy=%b, required 1 3 0 1", done_pulse, cur_code, busy, req_ready);
        end
        tick();
        vectors++;
        if (done_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL up_done_width: done=%b, required 0", done_pulse);
        end
    endtask

    task automatic test_downward();
        int order_bad = 0;
        settle_cycles_cfg = 8'd4;
        accept(3'd5);
        wait_done(40, "down_prep");
        accept(3'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (voltage_override < frequency_override) order_bad++;
            if (k == 1) begin
                vectors++;
                if ({frequency_override, voltage_override, clamp_pulse} !== {3'd1, 3'd5, 1'b0}) begin
                    miscompares++;
                    $display("FAIL down_T+1: f=%0d v=%0d clamp=%b, required f=1 v=5 clamp=0",
                             frequency_override, voltage_override, clamp_pulse);
                end
            end
            if (k == 5) begin
                vectors++;
                if (voltage_override !== 3'd5) begin
                    miscompares++;
                    $display("FAIL down_T+5: v=%0d, required 5", voltage_override);
                end
            end
            if (k == 6) begin
                vectors++;
                if (voltage_override !== 3'd1) begin
                    miscompares++;
                    $display("FAIL down_T+6: v=%0d, required 1", voltage_override);
                end
            end
            if (k == 10) begin
                vectors++;
                if ({done_pulse, cur_code} !== {1'b1, 3'd1}) begin
                    miscompares++;
                    $display("FAIL down_T+10: done=%b cur=%0d, required 1 1", done_pulse, cur_code);
                end
            end
        end
        vectors++;
        if (order_bad != 0) begin
            miscompares++;
            $display("FAIL down_order: %0d cycles with voltage below frequency, required 0", order_bad);
        end
    endtask

    task automatic test_clamp();
        settle_cycles_cfg = 8'd2;
        max_code_cfg      = 3'd4;
        accept(3'd7);
        vectors++;
        if (clamp_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_T: clamp=%b, required 0", clamp_pulse);
        end
        tick();
        vectors++;
        if ({clamp_pulse, voltage_override} !== {1'b1, 3'd4}) begin
            miscompares++;
            $display("FAIL clamp_ceiling_T+1: clamp=%b v=%0d, required 1 4", clamp_pulse, voltage_override);
        end
        wait_done(20, "clamp_ceiling");
        vectors++;
        if (cur_code !== 3'd4) begin
            miscompares++;
            $display("FAIL clamp_ceiling_cur: cur=%0d, required 4", cur_code);
        end
        max_code_cfg = 3'd7;
        accept(3'd7);
        tick();
        vectors++;
        if ({clamp_pulse, voltage_override} !== {1'b1, 3'd6}) begin
            miscompares++;
            $display("FAIL clamp_max_T+1: clamp=%b v=%0d, required 1 6", clamp_pulse, voltage_override);
        end
        wait_done(20, "clamp_max");
        vectors++;
        if (cur_code !== 3'd6) begin
            miscompares++;
            $display("FAIL clamp_max_cur: cur=%0d, required 6", cur_code);
        end
    endtask

    task automatic test_trip_mid();
        int dones = 0;
        settle_cycles_cfg = 8'd3;
        accept(3'd2);
        wait_done(30, "trip_prep");
        accept(3'd5);
        ticks(2);
        thermal_trip = 1'b1;
        ticks(2);
        thermal_trip = 1'b0;
        tick();
        vectors++;
        if ({frequency_override, req_ready} !== {3'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL trip_T+5: f=%0d rdy=%b, required 5 0", frequency_override, req_ready);
        end
        ticks(3);
        vectors++;
        if ({done_pulse, cur_code} !== {1'b1, 3'd5}) begin
            miscompares++;
            $display("FAIL trip_first_done_T+8: done=%b cur=%0d, required 1 5", done_pulse, cur_code);
        end
        for (int k = 9; k <= 16; k++) begin
            tick();
            if (done_pulse) dones++;
            if (k == 9) begin
                vectors++;
                if ({frequency_override, voltage_override} !== {3'd0, 3'd5}) begin
                    miscompares++;
                    $display("FAIL trip_T+9: f=%0d v=%0d, required 0 5", frequency_override, voltage_override);
                end
            end
            if (k == 13) begin
                vectors++;
                if (voltage_override !== 3'd0) begin
                    miscompares++;
                    $display("FAIL trip_T+13: v=%0d, required 0", voltage_override);
                end
            end
            if (k == 15) begin
                vectors++;
                if (req_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL trip_ready_T+15: rdy=%b, required 0", req_ready);
                end
            end
        end
        vectors++;
        if ({dones, done_pulse, cur_code, req_ready} !== {32'd1, 1'b1, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL trip_second_done_T+16: dones=%0d done=%b cur=%0d rdy=%b, required 1 1 0 1",
                     dones, done_pulse, cur_code, req_ready);
        end
    endtask

    task automatic test_trip_idle();
        settle_cycles_cfg = 8'd2;
        accept(3'd3);
        wait_done(20, "trip_idle_prep");
        thermal_trip = 1'b1;
        req_valid    = 1'b1;
        req_code     = 3'd6;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL trip_idle_ready: rdy=%b, required 0", req_ready);
        end
        tick();
        thermal_trip = 1'b0;
        req_valid    = 1'b0;
        tick();
        vectors++;
        if ({frequency_override, voltage_override, clamp_pulse} !== {3'd0, 3'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL trip_idle_T+1: f=%0d v=%0d clamp=%b, required 0 3 0",
                     frequency_override, voltage_override, clamp_pulse);
        end
        wait_done(20, "trip_idle");
        vectors++;
        if ({cur_code, voltage_override} !== {3'd0, 3'd0}) begin
            miscompares++;
            $display("FAIL trip_idle_final: cur=%0d v=%0d, required 0 0", cur_code, voltage_override);
        end
    endtask

    task automatic test_edge_cases();
        settle_cycles_cfg = 8'd0;
        accept(3'd2);
        ticks(2);
        vectors++;
        if (frequency_override !== 3'd0) begin
            miscompares++;
            $display("FAIL zero_settle_T+2: f=%0d, required 0", frequency_override);
        end
        tick();
        vectors++;
        if (frequency_override !== 3'd2) begin
            miscompares++;
            $display("FAIL zero_settle_T+3: f=%0d, required 2", frequency_override);
        end
        tick();
        vectors++;
        if ({done_pulse, cur_code} !== {1'b1, 3'd2}) begin
            miscompares++;
            $display("FAIL zero_settle_T+4: done=%b cur=%0d, required 1 2", done_pulse, cur_code);
        end
        accept(3'd2);
        vectors++;
        if (done_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL same_code_T: done=%b, required 0", done_pulse);
        end
        tick();
        vectors++;
        if ({done_pulse, busy, cur_code, frequency_override, voltage_override} !== {1'b1, 1'b0, 3'd2, 3'd2, 3'd2}) begin
            miscompares++;
            $display("FAIL same_code_T+1: done=%b busy=%b cur=%0d f=%0d v=%0d, required 1 0 2 2 2",
                     done_pulse, busy, cur_code, frequency_override, voltage_override);
        end
    endtask

    task automatic test_reset_mid();
        settle_cycles_cfg = 8'd5;
        accept(3'd5);
        ticks(8);
        vectors++;
        if ({busy, frequency_override} !== {1'b1, 3'd5}) begin
            miscompares++;
            $display("FAIL rst_mid_pre: busy=%b f=%0d, required 1 5", busy, frequency_override);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({cur_code, frequency_override, voltage_override, frequency_override_en,
             voltage_override_en, busy, done_pulse, clamp_pulse, req_ready} !== 15'b000_000_000_0_0_0_0_0_1) begin
            miscompares++;
            $display("FAIL rst_mid_values: cur=%0d f=%0d v=%0d fen=%b ven=%b busy=%b done=%b clamp=%b rdy=%b, required all 0 and rdy=1",
                     cur_code, frequency_override, voltage_override, frequency_override_en,
                     voltage_override_en, busy, done_pulse, clamp_pulse, req_ready);
        end
        settle_cycles_cfg = 8'd1;
        accept(3'd1);
        wait_done(10, "rst_mid_after");
        vectors++;
        if ({cur_code, voltage_override_en, frequency_override_en} !== {3'd1, 2'b11}) begin
            miscompares++;
            $display("FAIL rst_mid_after: cur=%0d ven=%b fen=%b, required 1 1 1",
                     cur_code, voltage_override_en, frequency_override_en);
        end
    endtask

    initial begin
        reset             = 1'b1;
        req_valid         = 1'b0;
        req_code          = 3'd0;
        max_code_cfg      = 3'd7;
        settle_cycles_cfg = 8'd1;
        thermal_trip      = 1'b0;
        test_reset();
        test_upward();
        test_downward();
        test_clamp();
        test_trip_mid();
        test_trip_idle();
        test_edge_cases();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dvfs_transition_sequencer.md
# dvfs_transition_sequencer

Sequences DVFS operating-point changes for one tile's `advanced_power_manager`. It drives that block's frequency/voltage override ports so the voltage/frequency ordering is always safe: voltage rises before frequency, and frequency falls before voltage. It enforces a programmable settle time after each step and clamps requests to a thermal ceiling. A thermal trip forces an emergency drop to code 0. It sits between the tile's power-policy firmware/CSR layer and the power manager.

## Interface
- `CODE_W`, 3: operating-point code width.
- `MAX_CODE`, 6: highest legal code; code 7 duplicates 6 in the characterization table.
- `clk`  in  1: core clock.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: target operating-point request.
- `req_code`  in  CODE_W: requested code.
- `req_ready`  out  1: sequencer can accept a request.
- `max_code_cfg`  in  CODE_W: thermal/policy ceiling.
- `settle_cycles_cfg`  in  8: wait after each step; a value of 0 is treated as 1.
- `thermal_trip`  in  1: level input; requests an emergency move to code 0.
- `frequency_override_en`  out  1: frequency override enable.
- `frequency_override`  out  CODE_W: frequency code.
- `voltage_override_en`  out  1: voltage override enable.
- `voltage_override`  out  CODE_W: voltage code.
- `cur_code`  out  CODE_W: committed operating point.
- `busy`  out  1: transition in progress.
- `done_pulse`  out  1: one-cycle completion strobe.
- `clamp_pulse`  out  1: one-cycle strobe when an accepted request was clamped.

## Operation
- **States:** IDLE, V_SET, V_WAIT, F_SET, F_WAIT.
- **Effective target:** `tgt = min(req_code, max_code_cfg, MAX_CODE)`. `tgt` is latched at accept. `clamp_pulse` fires the cycle after accept when `tgt != req_code`.
- **Accept condition:** `req_valid & req_ready`.
- **`req_ready` rule:** `req_ready = (state==IDLE) & ~trip_pending & ~thermal_trip`.
- **Upward move (`tgt > cur_code`):** IDLE→V_SET→V_WAIT→F_SET→F_WAIT→IDLE.
- **Downward move (`tgt < cur_code`):** IDLE→F_SET→F_WAIT→V_SET→V_WAIT→IDLE.
- **Same-code request (`tgt == cur_code`):** accepted, with no override change. `done_pulse` is asserted the cycle after accept and the state stays IDLE.
- **SET states:** last exactly one cycle. At exit they register the new override code and load the settle counter with `max(settle_cycles_cfg,1)`. `settle_cycles_cfg` is sampled at that moment.
- **WAIT states:** decrement the counter and exit when it reaches 0 after N counted cycles.
- **`cur_code` update:** `cur_code` updates to `tgt` when the final WAIT completes. `done_pulse` is asserted in that same cycle, on the registered output.
- **Override enables:** both `*_override_en` are 0 from reset. Both go 1 at the first SET exit and then stay 1 until reset.
- **Thermal trip in IDLE:** `thermal_trip` high in IDLE has priority over `req_valid` and starts a downward move with `tgt=0`. `clamp_pulse` is not asserted for this move.
- **Thermal trip mid-transition:** the trip sets `trip_pending`. The current transition is never aborted, so that the ordering stays safe. When the transition completes, the sequencer goes straight to F_SET with `tgt=0`, provided `cur_code>0`; otherwise it clears `trip_pending`. The trip move produces its own `done_pulse`.
- **Simultaneous trip and request:** when `thermal_trip` and `req_valid` occur in the same IDLE cycle, the trip wins and the request is not accepted because `req_ready=0`.
- **Override codes:** always stay within 0..MAX_CODE.

## Timing
- **Reset values:** state=IDLE; overrides=0; both en=0; `cur_code=0`; `busy=0`; `done_pulse=0`; `clamp_pulse=0`; `req_ready=1` unless a trip is active; `trip_pending=0`.
- **Reset mid-transition:** returns to the reset values on the next edge.
- **Accept edge T, settle N, non-trivial move:**
  - First override changes at edge T+1.
  - Second override changes at edge T+2+N.
  - `done_pulse` and `cur_code` update at edge T+2+2N.
  - `req_ready` is high again at T+2+2N.
- **`busy`:** 1 from T+1 through T+2+2N−1.
- **Same-code request:** latency is 1 cycle.
- **Output registration:** all outputs are registered except `req_ready`, which is combinational from state, `trip_pending` and `thermal_trip`.

## Structure
- **Package `dvfs_pkg`:**
  - state enum: IDLE, V_SET, V_WAIT, F_SET, F_WAIT.
  - `CODE_W`, `MAX_CODE`.
  - function `clamp_code(req, ceil)`.
- **Sub-module `dvfs_settle_timer`:**
  - 8-bit down-counter with `load`, `value` (0 loads as 1) and a one-cycle `expired` output.
  - Instantiated once and shared by both WAIT states.

## Test plan
1. **Upward move:** reset, N=20, `cur_code=0`, request code 3 → `voltage_override=3` at T+1; `frequency_override=3` at T+22; `done_pulse` and `cur_code=3` at T+42; override enables high from T+1.
2. **Downward move:** from code 5, request 1, N=4 → frequency changes to 1 at T+1, voltage changes to 1 at T+6, done at T+10; voltage is never below frequency at any cycle.
3. **Clamping:** `max_code_cfg=4`, request 7 → `clamp_pulse` at T+1, final `cur_code=4`. Separately, `max_code_cfg=7` with a request of 7 → final code 6 and a clamp pulse.
4. **Thermal trip:** trip asserted during V_WAIT of a 2→5 move → the move completes to 5, then frequency drops to 0 and then voltage drops to 0, giving two `done_pulse`s. `req_ready` stays 0 until the trip move is done and `thermal_trip` is low.
5. **Edge cases:** `settle_cycles_cfg=0` → behaves as N=1 (done at T+4). A same-code request → `done_pulse` at T+1 with no override change.
6. **Reset mid-transition:** reset during F_WAIT → all outputs return to their reset values next cycle; a new request is accepted afterwards.
